trace_retire_buf: RTL and testbench

- Parametrised, in-order retire-trace buffer for the simulation bench. It sits between the core's commit/write-back taps and the trace file writer.
- It captures one commit record per cycle and holds any record whose rd value is still outstanding (load or multi-cycle op).
- It patches that record from up to NWB late write-back ports, then emits completed records strictly in commit order on a valid/ready stream.
- This replaces file-seek patching with an in-hardware reorder.

---
 rtl/trace_pkg.sv | 40 ++++
 rtl/trace_pend_tbl.sv | 84 ++++++++
 rtl/trace_retire_buf.sv | 182 ++++++++++++++++++
 tb/tb_trace_retire_buf.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the retire-trace buffer: slot states, record layout, store-data shaping.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package trace_pkg;

  // Record layout widths; the buffer's XLEN/RADDR_W parameters must match these.
  localparam int TRC_XLEN    = 32;
  localparam int TRC_RADDR_W = 7;

  // Architectural x0: writes to it never produce or patch a trace record.
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } slot_state_e;

  typedef struct packed {
    logic [TRC_XLEN-1:0]    pc;
    logic [TRC_RADDR_W-1:0] rd_addr;
    logic [TRC_XLEN-1:0]    rd_data;
    logic [2:0]             mem_wen;
    logic [TRC_XLEN-1:0]    mem_waddr;
    logic [TRC_XLEN-1:0]    mem_wdata;
    logic [TRC_XLEN-1:0]    mem_raddr;
  } trace_rec_t;

  // Keep only the bytes the store actually wrote; smallest size wins if the one-hot is malformed.
  function automatic logic [TRC_XLEN-1:0] shape_wdata(input logic [2:0]          wen,
                                                      input logic [TRC_XLEN-1:0] data);
    logic [TRC_XLEN-1:0] r;
    r = '0;
    if (wen[0])      r[7:0]  = data[7:0];
    else if (wen[1]) r[15:0] = data[15:0];
    else if (wen[2]) r       = data;
    return r;
  endfunction

endpackage

// File: rtl/trace_pend_tbl.sv
// Register->slot map of records still waiting for a late rd value; NWB lookup ports, WAW detect.
// Latency: lookups are combinational on the pre-edge table; updates land at the next clk_i edge.
// Backpressure: none; every write-back is resolved in the cycle it arrives (hit or orphan).
module trace_pend_tbl
  import trace_pkg::*;
#(
  parameter int NWB     = 2,
  parameter int RADDR_W = 7,
  parameter int SLOT_W  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NWB-1:0]        wb_en,
  input  logic [NWB*RADDR_W-1:0] wb_addr,
  input  logic                  cap_en,
  input  logic [RADDR_W-1:0]    cap_addr,
  input  logic [SLOT_W-1:0]     cap_slot,
  output logic [NWB-1:0]        wb_hit,
  output logic [NWB*SLOT_W-1:0] wb_slot,
  output logic                  orphan,
  output logic                  waw,
  output logic [SLOT_W-1:0]     waw_slot
);

  localparam int NREG = 1 << RADDR_W;

  logic [NREG-1:0]   vld_q;
  logic [SLOT_W-1:0] slot_q [NREG];

  logic [NWB-1:0] elig;
  logic [NWB-1:0] dup;
  logic           cap_cleared;

  // Resolve each write-back port: lowest port wins a shared address, losers and misses are orphans.
  always_comb begin
    wb_hit      = '0;
    wb_slot     = '0;
    orphan      = 1'b0;
    elig        = '0;
    dup         = '0;
    cap_cleared = 1'b0;
    for (int k = 0; k < NWB; k++) begin
      elig[k] = wb_en[k] && (wb_addr[k*RADDR_W +: 5] != REG_ZERO);
      for (int j = 0; j < k; j++) begin
        if (elig[j] && (wb_addr[j*RADDR_W +: RADDR_W] == wb_addr[k*RADDR_W +: RADDR_W]))
          dup[k] = 1'b1;
      end
      if (elig[k]) begin
        if (!dup[k] && vld_q[wb_addr[k*RADDR_W +: RADDR_W]]) begin
          wb_hit[k]                   = 1'b1;
          wb_slot[k*SLOT_W +: SLOT_W] = slot_q[wb_addr[k*RADDR_W +: RADDR_W]];
          if (wb_addr[k*RADDR_W +: RADDR_W] == cap_addr)
            cap_cleared = 1'b1;
        end else begin
          orphan = 1'b1;
        end
      end
    end
    // A same-cycle write-back already retires the old owner, so that is not a WAW.
    waw      = cap_en && vld_q[cap_addr] && !cap_cleared;
    waw_slot = slot_q[cap_addr];
  end

  // Valid bits: clear on write-back hit, then a new pending capture claims the entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else begin
      for (int k = 0; k < NWB; k++) begin
        if (wb_hit[k])
          vld_q[wb_addr[k*RADDR_W +: RADDR_W]] <= 1'b0;
      end
      if (cap_en)
        vld_q[cap_addr] <= 1'b1;
    end
  end

  // Slot pointers carry no meaning while the valid bit is clear, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (cap_en)
      slot_q[cap_addr] <= cap_slot;
  end

endmodule

// File: rtl/trace_retire_buf.sv
// In-order retire-trace buffer: captures commits, patches late rd values, emits records in commit order.
// Latency: a complete record is on trc_* the cycle after its capture or completing write-back edge.
// Backpressure: trc_rdy stalls the head only; the core is never stalled, a full buffer drops and sets ovf.
module trace_retire_buf
  import trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int NWB     = 2,
  parameter int XLEN    = TRC_XLEN,
  parameter int RADDR_W = TRC_RADDR_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmt_vld,
  input  logic [XLEN-1:0]         cmt_pc,
  input  logic                    cmt_rd_en,
  input  logic [RADDR_W-1:0]      cmt_rd_addr,
  input  logic                    cmt_rd_pend,
  input  logic [XLEN-1:0]         cmt_rd_wdata,
  input  logic [2:0]              cmt_mem_ren,
  input  logic [XLEN-1:0]         cmt_mem_raddr,
  input  logic [2:0]              cmt_mem_wen,
  input  logic [XLEN-1:0]         cmt_mem_waddr,
  input  logic [XLEN-1:0]         cmt_mem_wdata,
  input  logic [NWB-1:0]          wb_en,
  input  logic [NWB*RADDR_W-1:0]  wb_addr,
  input  logic [NWB*XLEN-1:0]     wb_data,
  output logic                    trc_vld,
  input  logic                    trc_rdy,
  output logic [31:0]             trc_idx,
  output logic [XLEN-1:0]         trc_pc,
  output logic [RADDR_W-1:0]      trc_rd_addr,
  output logic [XLEN-1:0]         trc_rd_data,
  output logic [2:0]              trc_mem_wen,
  output logic [XLEN-1:0]         trc_mem_waddr,
  output logic [XLEN-1:0]         trc_mem_wdata,
  output logic [XLEN-1:0]         trc_mem_raddr,
  output logic                    ovf,
  output logic                    err_orphan,
  output logic                    err_waw
);

  localparam int             PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

  slot_state_e      state_q [DEPTH];
  trace_rec_t       rec_q   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [31:0]      idx_q;
  logic             ovf_q;
  logic             orphan_q;
  logic             waw_q;

  logic       rd_ok;
  logic       rec_ok;
  logic       pop;
  logic       cap;
  logic       pend_cap;
  trace_rec_t cap_rec;
  trace_rec_t head;

  logic [NWB-1:0]       wb_hit;
  logic [NWB*PTR_W-1:0] wb_slot;
  logic                 wb_orphan;
  logic                 waw;
  logic [PTR_W-1:0]     waw_slot;

  // Filter the commit, decide accept/drop, and shape the fields into a record.
  always_comb begin
    rd_ok    = cmt_rd_en && (cmt_rd_addr[4:0] != REG_ZERO);
    rec_ok   = cmt_vld && (rd_ok || (cmt_mem_wen != 3'b000));
    trc_vld  = (state_q[rd_ptr_q] == DONE);
    pop      = trc_vld && trc_rdy;
    // At full, the slot freed by a same-cycle pop is exactly the one wr_ptr points at.
    cap      = rec_ok && ((count_q != DEPTH_CNT) || pop);
    pend_cap = cap && rd_ok && cmt_rd_pend;

    cap_rec           = '0;
    cap_rec.pc        = cmt_pc;
    cap_rec.rd_addr   = rd_ok ? cmt_rd_addr : '0;
    cap_rec.rd_data   = rd_ok ? cmt_rd_wdata : '0;
    cap_rec.mem_wen   = cmt_mem_wen;
    cap_rec.mem_waddr = (cmt_mem_wen != 3'b000) ? cmt_mem_waddr : '0;
    cap_rec.mem_wdata = shape_wdata(cmt_mem_wen, cmt_mem_wdata);
    cap_rec.mem_raddr = (cmt_mem_ren != 3'b000) ? cmt_mem_raddr : '0;
  end

  trace_pend_tbl #(
    .NWB     (NWB),
    .RADDR_W (RADDR_W),
    .SLOT_W  (PTR_W)
  ) u_pend_tbl (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .cap_en   (pend_cap),
    .cap_addr (cmt_rd_addr),
    .cap_slot (wr_ptr_q),
    .wb_hit   (wb_hit),
    .wb_slot  (wb_slot),
    .orphan   (wb_orphan),
    .waw      (waw),
    .waw_slot (waw_slot)
  );

  // Slot array: pop frees the head, write-backs and WAW complete slots, capture fills wr_ptr last.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= FREE;
        rec_q[i]   <= '0;
      end
    end else begin
      if (pop)
        state_q[rd_ptr_q] <= FREE;
      for (int k = 0; k < NWB; k++) begin
        if (wb_hit[k]) begin
          state_q[wb_slot[k*PTR_W +: PTR_W]]       <= DONE;
          rec_q[wb_slot[k*PTR_W +: PTR_W]].rd_data <= wb_data[k*XLEN +: XLEN];
        end
      end
      // The superseded record keeps the rd value it was captured with.
      if (waw)
        state_q[waw_slot] <= DONE;
      if (cap) begin
        state_q[wr_ptr_q] <= pend_cap ? PEND : DONE;
        rec_q[wr_ptr_q]   <= cap_rec;
      end
    end
  end

  // Pointers, occupancy, emitted-sequence number and sticky error flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      orphan_q <= 1'b0;
      waw_q    <= 1'b0;
    end else begin
      if (cap)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        idx_q    <= idx_q + 32'd1;
      end
      case ({cap, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (rec_ok && !cap)
        ovf_q <= 1'b1;
      if (wb_orphan)
        orphan_q <= 1'b1;
      if (waw)
        waw_q <= 1'b1;
    end
  end

  // Head record drives the trace stream directly.
  always_comb begin
    head          = rec_q[rd_ptr_q];
    trc_idx       = idx_q;
    trc_pc        = head.pc;
    trc_rd_addr   = head.rd_addr;
    trc_rd_data   = head.rd_data;
    trc_mem_wen   = head.mem_wen;
    trc_mem_waddr = head.mem_waddr;
    trc_mem_wdata = head.mem_wdata;
    trc_mem_raddr = head.mem_raddr;
    ovf           = ovf_q;
    err_orphan    = orphan_q;
    err_waw       = waw_q;
  end

endmodule

// File: tb/tb_trace_retire_buf.sv
module tb_trace_retire_buf;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmt_vld;
  logic [31:0] cmt_pc;
  logic        cmt_rd_en;
  logic [6:0]  cmt_rd_addr;
  logic        cmt_rd_pend;
  logic [31:0] cmt_rd_wdata;
  logic [2:0]  cmt_mem_ren;
  logic [31:0] cmt_mem_raddr;
  logic [2:0]  cmt_mem_wen;
  logic [31:0] cmt_mem_waddr;
  logic [31:0] cmt_mem_wdata;
  logic [1:0]  wb_en;
  logic [13:0] wb_addr;
  logic [63:0] wb_data;
  logic        trc_vld;
  logic        trc_rdy;
  logic [31:0] trc_idx;
  logic [31:0] trc_pc;
  logic [6:0]  trc_rd_addr;
  logic [31:0] trc_rd_data;
  logic [2:0]  trc_mem_wen;
  logic [31:0] trc_mem_waddr;
  logic [31:0] trc_mem_wdata;
  logic [31:0] trc_mem_raddr;
  logic        ovf;
  logic        err_orphan;
  logic        err_waw;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] pc;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data;
    logic [2:0]  wen;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
  } exp_t;

  exp_t exp_q[$];
  int   exp_idx = 0;
  int   checks  = 0;
  int   errors  = 0;

  trace_retire_buf #(.DEPTH(4), .NWB(2), .XLEN(32), .RADDR_W(7)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmt_vld(cmt_vld), .cmt_pc(cmt_pc), .cmt_rd_en(cmt_rd_en), .cmt_rd_addr(cmt_rd_addr),
    .cmt_rd_pend(cmt_rd_pend), .cmt_rd_wdata(cmt_rd_wdata), .cmt_mem_ren(cmt_mem_ren),
    .cmt_mem_raddr(cmt_mem_raddr), .cmt_mem_wen(cmt_mem_wen), .cmt_mem_waddr(cmt_mem_waddr),
    .cmt_mem_wdata(cmt_mem_wdata), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .trc_vld(trc_vld), .trc_rdy(trc_rdy), .trc_idx(trc_idx), .trc_pc(trc_pc),
    .trc_rd_addr(trc_rd_addr), .trc_rd_data(trc_rd_data), .trc_mem_wen(trc_mem_wen),
    .trc_mem_waddr(trc_mem_waddr), .trc_mem_wdata(trc_mem_wdata), .trc_mem_raddr(trc_mem_raddr),
    .ovf(ovf), .err_orphan(err_orphan), .err_waw(err_waw)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard monitor: every accepted trace beat must match the oldest expected record.
  always @(negedge clk_i) begin
    exp_t got;
    exp_t e;
    if (!rst_i && trc_vld && trc_rdy) begin
      got = {trc_idx, trc_pc, trc_rd_addr, trc_rd_data, trc_mem_wen,
             trc_mem_waddr, trc_mem_wdata, trc_mem_raddr};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rec: got idx=%0d pc=%h rd=%0d data=%h, required no record",
                 trc_idx, trc_pc, trc_rd_addr, trc_rd_data);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL rec_%0d: got pc=%h rd=%0d rdata=%h wen=%b wa=%h wd=%h ra=%h idx=%0d, required pc=%h rd=%0d rdata=%h wen=%b wa=%h wd=%h ra=%h idx=%0d",
                   e.idx, got.pc, got.rd_addr, got.rd_data, got.wen, got.waddr, got.wdata, got.raddr, got.idx,
                   e.pc, e.rd_addr, e.rd_data, e.wen, e.waddr, e.wdata, e.raddr, e.idx);
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic commit(input logic [31:0] pc, input logic rd_en, input logic [6:0] rd,
                        input logic pend, input logic [31:0] rdata,
                        input logic [2:0] ren, input logic [31:0] raddr,
                        input logic [2:0] wen, input logic [31:0] waddr, input logic [31:0] wdata);
    cmt_vld = 1'b1; cmt_pc = pc; cmt_rd_en = rd_en; cmt_rd_addr = rd; cmt_rd_pend = pend;
    cmt_rd_wdata = rdata; cmt_mem_ren = ren; cmt_mem_raddr = raddr;
    cmt_mem_wen = wen; cmt_mem_waddr = waddr; cmt_mem_wdata = wdata;
    tick();
    cmt_vld = 1'b0; cmt_rd_en = 1'b0; cmt_rd_pend = 1'b0; cmt_mem_ren = '0; cmt_mem_wen = '0;
  endtask

  task automatic alu(input logic [31:0] pc, input logic [6:0] rd, input logic [31:0] d);
    commit(pc, 1'b1, rd, 1'b0, d, 3'b000, 32'h0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic ld_pend(input logic [31:0] pc, input logic [6:0] rd, input logic [31:0] d,
                         input logic [31:0] raddr);
    commit(pc, 1'b1, rd, 1'b1, d, 3'b100, raddr, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic set_wb(input logic [1:0] en, input logic [6:0] a0, input logic [31:0] d0,
                        input logic [6:0] a1, input logic [31:0] d1);
    wb_en = en; wb_addr = {a1, a0}; wb_data = {d1, d0};
  endtask

  task automatic wb(input logic [1:0] en, input logic [6:0] a0, input logic [31:0] d0,
                    input logic [6:0] a1, input logic [31:0] d1);
    set_wb(en, a0, d0, a1, d1);
    tick();
    wb_en = '0;
  endtask

  task automatic expect_rec(input logic [31:0] pc, input logic [6:0] rd, input logic [31:0] rdata,
                            input logic [2:0] wen, input logic [31:0] waddr,
                            input logic [31:0] wdata, input logic [31:0] raddr);
    exp_q.push_back({exp_idx[31:0], pc, rd, rdata, wen, waddr, wdata, raddr});
    exp_idx++;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    tick();
    chk(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; cmt_vld = 0; cmt_pc = 0; cmt_rd_en = 0; cmt_rd_addr = 0; cmt_rd_pend = 0;
    cmt_rd_wdata = 0; cmt_mem_ren = 0; cmt_mem_raddr = 0; cmt_mem_wen = 0; cmt_mem_waddr = 0;
    cmt_mem_wdata = 0; wb_en = 0; wb_addr = 0; wb_data = 0; trc_rdy = 1'b0;
    #12;
    chk("rst_trc_vld", trc_vld, 0);
    chk("rst_trc_idx", trc_idx, 0);
    chk("rst_trc_pc", trc_pc, 0);
    chk("rst_flags", {ovf, err_orphan, err_waw}, 0);
    @(negedge clk_i); rst_i = 1'b0;
    tick();
    trc_rdy = 1'b1;

    // Back-to-back ALU records, then two commits the filter must drop.
    expect_rec(32'h1000, 7'd5, 32'h11, 3'b000, 32'h0, 32'h0, 32'h0);
    alu(32'h1000, 7'd5, 32'h11);
    expect_rec(32'h1004, 7'd6, 32'h22, 3'b000, 32'h0, 32'h0, 32'h0);
    alu(32'h1004, 7'd6, 32'h22);
    alu(32'h1008, 7'd0, 32'h99);
    commit(32'h100C, 1'b1, 7'h20, 1'b0, 32'h98, 3'b000, 32'h0, 3'b000, 32'h0, 32'h0);
    commit(32'h1010, 1'b0, 7'd3, 1'b0, 32'h97, 3'b001, 32'h50, 3'b000, 32'h0, 32'h0);
    drain("drain_alu");
    chk("filtered_no_vld", trc_vld, 0);

    // Store shaping: byte, half-over-word priority, rd=x0 store, non-pending load.
    expect_rec(32'h2000, 7'd0, 32'h0, 3'b001, 32'h100, 32'h000000DD, 32'h0);
    commit(32'h2000, 1'b0, 7'd0, 1'b0, 32'h0, 3'b000, 32'h0, 3'b001, 32'h100, 32'hAABBCCDD);
    expect_rec(32'h2004, 7'd0, 32'h0, 3'b110, 32'h104, 32'h0000CCDD, 32'h0);
    commit(32'h2004, 1'b0, 7'd0, 1'b0, 32'h0, 3'b000, 32'h999, 3'b110, 32'h104, 32'hAABBCCDD);
    expect_rec(32'h2008, 7'd0, 32'h0, 3'b100, 32'h108, 32'h12345678, 32'h0);
    commit(32'h2008, 1'b1, 7'd0, 1'b0, 32'h55, 3'b000, 32'h0, 3'b100, 32'h108, 32'h12345678);
    expect_rec(32'h200C, 7'd7, 32'h77, 3'b000, 32'h0, 32'h0, 32'h200);
    commit(32'h200C, 1'b1, 7'd7, 1'b0, 32'h77, 3'b100, 32'h200, 3'b000, 32'h333, 32'h0);
    drain("drain_store");

    // Pending load blocks a younger ALU record until its write-back arrives on port 1.
    expect_rec(32'h3000, 7'd10, 32'hCAFEF00D, 3'b000, 32'h0, 32'h0, 32'h400);
    ld_pend(32'h3000, 7'd10, 32'hDEAD, 32'h400);
    expect_rec(32'h3004, 7'd11, 32'h5, 3'b000, 32'h0, 32'h0, 32'h0);
    alu(32'h3004, 7'd11, 32'h5);
    chk("pend_blocks_0", trc_vld, 0);
    tick();
    chk("pend_blocks_1", trc_vld, 0);
    wb(2'b10, 7'd0, 32'h0, 7'd10, 32'hCAFEF00D);
    chk("wb_head_vld", trc_vld, 1);
    drain("drain_pend");
    chk("no_orphan_yet", err_orphan, 0);

    // Two ports write the same pending register: port 0 wins, port 1 is an orphan.
    expect_rec(32'h4000, 7'd10, 32'h11110000, 3'b000, 32'h0, 32'h0, 32'h400);
    ld_pend(32'h4000, 7'd10, 32'h0, 32'h400);
    wb(2'b11, 7'd10, 32'h11110000, 7'd10, 32'h22220000);
    chk("dual_wb_orphan", err_orphan, 1);
    drain("drain_dual");
    wb(2'b01, 7'd12, 32'h12, 7'd0, 32'h0);
    chk("orphan_x12", err_orphan, 1);
    chk("orphan_no_vld", trc_vld, 0);

    // Same-cycle write-back and new pending capture to x14: no WAW.
    expect_rec(32'h5000, 7'd14, 32'h4444, 3'b000, 32'h0, 32'h0, 32'h400);
    ld_pend(32'h5000, 7'd14, 32'h0, 32'h400);
    expect_rec(32'h5004, 7'd14, 32'h5555, 3'b000, 32'h0, 32'h0, 32'h404);
    set_wb(2'b01, 7'd14, 32'h4444, 7'd0, 32'h0);
    ld_pend(32'h5004, 7'd14, 32'h0, 32'h404);
    wb_en = '0;
    chk("same_cycle_no_waw", err_waw, 0);
    wb(2'b01, 7'd14, 32'h5555, 7'd0, 32'h0);
    // Real WAW on x13: the older record completes with its captured value.
    expect_rec(32'h5008, 7'd13, 32'h13131313, 3'b000, 32'h0, 32'h0, 32'h408);
    ld_pend(32'h5008, 7'd13, 32'h13131313, 32'h408);
    expect_rec(32'h500C, 7'd13, 32'hBBBB, 3'b000, 32'h0, 32'h0, 32'h40C);
    ld_pend(32'h500C, 7'd13, 32'hAAAA, 32'h40C);
    chk("waw_set", err_waw, 1);
    wb(2'b01, 7'd13, 32'hBBBB, 7'd0, 32'h0);
    drain("drain_waw");

    // Overflow at DEPTH=4, then a capture alongside a pop at full.
    chk("ovf_clear", ovf, 0);
    trc_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_rec(32'h6000 + 4 * i, 7'd1 + i[6:0], 32'h60 + i, 3'b000, 32'h0, 32'h0, 32'h0);
      alu(32'h6000 + 4 * i, 7'd1 + i[6:0], 32'h60 + i);
      if (i == 3) chk("ovf_at_4", ovf, 0);
    end
    chk("ovf_after_5", ovf, 1);
    chk("full_head_pc", trc_pc, 32'h6000);
    trc_rdy = 1'b1;
    expect_rec(32'h6100, 7'd6, 32'h66, 3'b000, 32'h0, 32'h0, 32'h0);
    alu(32'h6100, 7'd6, 32'h66);
    drain("drain_full");

    // Asynchronous reset mid-stream with three pending records.
    ld_pend(32'h7000, 7'd20, 32'h0, 32'h500);
    ld_pend(32'h7004, 7'd21, 32'h0, 32'h504);
    ld_pend(32'h7008, 7'd22, 32'h0, 32'h508);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_trc_vld", trc_vld, 0);
    chk("arst_flags", {ovf, err_orphan, err_waw}, 0);
    chk("arst_idx", trc_idx, 0);
    chk("arst_pc", trc_pc, 0);
    exp_q.delete();
    exp_idx = 0;
    @(negedge clk_i); rst_i = 1'b0;
    tick();
    wb(2'b01, 7'd20, 32'h20, 7'd0, 32'h0);
    chk("post_rst_orphan", err_orphan, 1);
    chk("post_rst_no_vld", trc_vld, 0);
    // Occupancy restarted at zero: four more captures fit without overflow.
    trc_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_rec(32'h8000 + 4 * i, 7'd9, 32'h90 + i, 3'b000, 32'h0, 32'h0, 32'h0);
      alu(32'h8000 + 4 * i, 7'd9, 32'h90 + i);
    end
    chk("post_rst_no_ovf", ovf, 0);
    trc_rdy = 1'b1;
    drain("drain_post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
